// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the PC unit and decode.
// Issues one instruction-memory read at a time and buffers {pc, instr} pairs
// in a DEPTH-entry circular queue. A flush (taken branch) discards the
// queued entries and the outstanding read.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a response
// that arrives while the queue is empty goes straight to decode in the
// same cycle.
module fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  pc_en,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   req_pc_reg;
  logic [DATA_WIDTH-1:0]   pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]          count_reg;

  logic issue;
  logic push;
  logic pop;
  logic q_valid;
  logic bypass_hit;
  logic bypass_take;

  // A response arriving while the queue is empty can be handed to decode
  // directly; if decode takes it, the entry never enters the queue.
`ifdef FETCH_BYPASS_EN
  assign bypass_hit = (state_reg == WAIT) && imem_rvalid && !flush && (count_reg == '0);
`else
  assign bypass_hit = 1'b0;
`endif
  assign bypass_take = bypass_hit && instr_ready;

  assign q_valid = (count_reg != '0);
  // Pops are meaningless during a flush because the queue is cleared anyway.
  assign pop     = q_valid && instr_ready && !flush;

  // Next-state and request logic; issue is held off while reset is high so
  // every output reads zero during reset.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rst && !flush && (count_reg < FULL_COUNT)) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          // Data returned together with a flush belongs to the old path.
          push       = !flush && !bypass_take;
          state_next = IDLE;
        end else if (flush) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_rvalid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_req  = issue;
  assign pc_en     = issue;
  assign imem_addr = issue ? pc_in : '0;

  // Head of queue, or the bypassed response, or zeros when nothing is valid.
  always_comb begin
    instr_valid = q_valid || bypass_hit;
    instr       = '0;
    instr_pc    = '0;
    if (q_valid) begin
      instr    = data_q[rd_ptr_reg];
      instr_pc = pc_q[rd_ptr_reg];
    end else if (bypass_hit) begin
      instr    = imem_rdata;
      instr_pc = req_pc_reg;
    end
  end

  // FSM state and the PC of the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      req_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        req_pc_reg <= pc_in;
      end
    end
  end

  // Queue pointers and occupancy; a flush empties the queue in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Queue storage; the write slot is always free because issue needs room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      pc_q[wr_ptr_reg]   <= req_pc_reg;
      data_q[wr_ptr_reg] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (DEPTH=2, DATA_WIDTH=32).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_en       (pc_en),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are then driven 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    flush       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    pc_in       = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    flush       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b1;
    pc_in       = 32'h0000_0abc;
    #2;
    checks++;
    if ({pc_en, imem_req, instr_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000", {pc_en, imem_req, instr_valid});
    end
    checks++;
    if ({imem_addr, instr, instr_pc} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {imem_addr, instr, instr_pc});
    end
    tick();
    rst = 1'b0;
    pc_in = 32'h0;
    $display("test_reset done");
  endtask

  task automatic test_first_fetch();
    do_reset();
    instr_ready = 1'b1;
    pc_in = 32'h0;
    #1;
    checks++;
    if ({imem_req, pc_en} !== 2'b11 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_issue got=%b addr=%h exp=11 addr=0", {imem_req, pc_en}, imem_addr);
    end
    tick();
    pc_in       = 32'h4;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL first_wait_req got=%b exp=0", imem_req);
    end
`ifdef FETCH_BYPASS_EN
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL first_bypass got=%b %h %h exp=1 00500093 0", instr_valid, instr, instr_pc);
    end
`else
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_c2_valid got=%b exp=0", instr_valid);
    end
    tick();
    imem_rvalid = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL first_c3 got=%b %h %h exp=1 00500093 0", instr_valid, instr, instr_pc);
    end
`endif
    $display("test_first_fetch pc=0 instr=00500093");
  endtask

  task automatic test_fill_drain();
    do_reset();
    instr_ready = 1'b0;
    pc_in = 32'h0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_0000; pc_in = 32'h4;
    tick();
    imem_rvalid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      failures++;
      $display("FAIL fill_issue2 got=%b addr=%h exp=1 addr=4", imem_req, imem_addr);
    end
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_0004; pc_in = 32'h8;
    tick();
    imem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({imem_req, pc_en} !== 2'b00) begin
        failures++;
        $display("FAIL full_no_req cyc=%0d got=%b exp=00", c, {imem_req, pc_en});
      end
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h1111_0000) begin
        failures++;
        $display("FAIL full_head cyc=%0d got=%b %h %h exp=1 0 11110000", c, instr_valid, instr_pc, instr);
      end
      tick();
    end
    instr_ready = 1'b1;
    #1;
    checks++;
    if (instr_pc !== 32'h0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL drain0 got=%h req=%b exp=0 req=0", instr_pc, imem_req);
    end
    $display("test_fill_drain pop pc=%h", instr_pc);
    tick();
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== 32'h2222_0004) begin
      failures++;
      $display("FAIL drain1 got=%b %h %h exp=1 4 22220004", instr_valid, instr_pc, instr);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL refetch8 got=%b addr=%h exp=1 addr=8", imem_req, imem_addr);
    end
    $display("test_fill_drain pop pc=%h", instr_pc);
    tick();
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL drained_empty got=%b exp=0", instr_valid);
    end
  endtask

  task automatic test_flush_discard();
    do_reset();
    pc_in = 32'h10;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL fl_issue got=%b addr=%h exp=1 addr=10", imem_req, imem_addr);
    end
    tick();
    flush = 1'b1; pc_in = 32'h40;
    #1;
    checks++;
    if ({pc_en, imem_req} !== 2'b00) begin
      failures++;
      $display("FAIL fl_strobe got=%b exp=00", {pc_en, imem_req});
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      failures++;
      $display("FAIL discard_wait got=%b exp=00", {imem_req, instr_valid});
    end
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL discard_resp_req got=%b exp=0", imem_req);
    end
    tick();
    imem_rvalid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_discard got=req%b addr=%h v=%b exp=req1 addr=40 v=0", imem_req, imem_addr, instr_valid);
    end
    $display("test_flush_discard dropped deadbeef, refetch pc=%h", imem_addr);
  endtask

  task automatic test_flush_with_rvalid();
    do_reset();
    pc_in = 32'h0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0000; pc_in = 32'h4;
    tick();
    imem_rvalid = 1'b0;
    tick();
    flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0004; pc_in = 32'h80;
    #1;
    checks++;
    if (pc_en !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL flrv_cycle got=en%b v=%b pc=%h exp=en0 v=1 pc=0", pc_en, instr_valid, instr_pc);
    end
    tick();
    flush = 1'b0; imem_rvalid = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL flrv_empty got=%b %h %h exp=0 0 0", instr_valid, instr, instr_pc);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      failures++;
      $display("FAIL flrv_reissue got=%b addr=%h exp=1 addr=80", imem_req, imem_addr);
    end
    $display("test_flush_with_rvalid refetch pc=%h", imem_addr);
  endtask

  task automatic test_wrap();
    logic        pend;
    logic [31:0] pend_addr;
    logic        req_now;
    logic        en_now;
    logic [31:0] addr_now;
    logic [31:0] exp_pc;
    int          pops;
    do_reset();
    pend = 1'b0; pend_addr = '0; exp_pc = '0; pops = 0;
    for (int cyc = 0; cyc < 200 && pops < 6; cyc++) begin
      imem_rvalid = pend;
      imem_rdata  = pend_addr ^ 32'hA500_0000;
      instr_ready = cyc[0];
      #1;
      if (instr_valid && instr_ready) begin
        checks++;
        if (instr_pc !== exp_pc) begin
          failures++;
          $display("FAIL wrap_pc got=%h exp=%h", instr_pc, exp_pc);
        end
        checks++;
        if (instr !== (exp_pc ^ 32'hA500_0000)) begin
          failures++;
          $display("FAIL wrap_instr got=%h exp=%h", instr, exp_pc ^ 32'hA500_0000);
        end
        $display("test_wrap pop pc=%h instr=%h", instr_pc, instr);
        exp_pc += 32'h4;
        pops++;
      end
      req_now  = imem_req;
      en_now   = pc_en;
      addr_now = imem_addr;
      tick();
      pend      = req_now;
      pend_addr = addr_now;
      if (en_now) pc_in = pc_in + 32'h4;
    end
    checks++;
    if (pops != 6) begin
      failures++;
      $display("FAIL wrap_timeout got=%0d pops exp=6", pops);
    end
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pc_in = 32'h0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hCCCC_0000; pc_in = 32'h4;
    tick();
    imem_rvalid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({pc_en, imem_req, instr_valid} !== 3'b000 || {imem_addr, instr, instr_pc} !== 96'h0) begin
      failures++;
      $display("FAIL rst_mid got=%b %h %h %h exp=000 0 0 0", {pc_en, imem_req, instr_valid}, imem_addr, instr, instr_pc);
    end
    tick();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hEEEE_0004; pc_in = 32'h100;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL rst_late_resp got=v%b req%b addr=%h exp=v0 req1 addr=100", instr_valid, imem_req, imem_addr);
    end
    tick();
    imem_rvalid = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_late_dropped got=%b exp=0", instr_valid);
    end
    $display("test_reset_mid late response ignored");
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_fill_drain();
    test_flush_discard();
    test_flush_with_rvalid();
    test_wrap();
    test_reset_mid();
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the PC unit.
- Takes the current PC, issues one instruction-memory read at a time, and buffers returned instructions with their PCs in a small queue for decode.
- Produces `pc_en`, which strobes the PC unit to advance.
- Discards in-flight and queued instructions when a taken branch (`PCSrc`) redirects the PC.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction words.
- DEPTH, 2, instruction queue entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_in  input  DATA_WIDTH  current PC (`PCout` of the PC unit).
- pc_en  output  1  one-cycle strobe: PC unit advances to its next value.
- flush  input  1  redirect (driven by `PCSrc`); discard all fetch state this cycle.
- imem_req  output  1  read request, accepted the cycle it is high.
- imem_addr  output  DATA_WIDTH  read address, equal to `pc_in` when `imem_req`=1.
- imem_rvalid  input  1  read data valid; arrives at least 1 cycle after the request.
- imem_rdata  input  DATA_WIDTH  instruction word.
- instr_valid  output  1  queue head valid.
- instr  output  DATA_WIDTH  queue head instruction.
- instr_pc  output  DATA_WIDTH  PC of the queue head instruction.
- instr_ready  input  1  decode consumes the head when `instr_valid`&`instr_ready`.

Behaviour:
- Reset (async, immediate):
  - State IDLE; queue empty (count 0); `pc_en`=0, `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - Reset mid-transaction abandons the outstanding read.
- FSM states: IDLE, WAIT, DISCARD.
- IDLE:
  - `imem_req`=1 and `pc_en`=1 combinationally iff `flush`=0 and count<DEPTH.
  - On issue, latch `pc_in` as `req_pc` and go to WAIT.
  - `imem_rvalid` in IDLE is ignored.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`: push {`req_pc`, `imem_rdata`} to the queue, return to IDLE. The next request may issue in the following cycle.
  - On `flush` without `rvalid`: go to DISCARD.
  - On `flush` with `rvalid`: drop the data, go to IDLE.
- DISCARD:
  - `imem_req`=0.
  - On `imem_rvalid`: drop the data, go to IDLE.
  - A further `flush` keeps the state in DISCARD.
- At most one read is outstanding. Issue requires count<DEPTH, so a push never overflows. Push and pop in the same cycle are both honoured; count is unchanged.
- Flush:
  - Count is cleared to 0 on the next edge; the pop in that cycle is irrelevant; no push occurs.
  - `instr_valid` is 0 the cycle after the flush.
- Queue:
  - Circular buffer with log2(DEPTH)-bit read/write pointers wrapping modulo DEPTH, and a count of log2(DEPTH)+1 bits.
  - `instr_valid`=(count!=0).
  - `instr`/`instr_pc` come from the head entry registers.
  - Outputs are 0 when the queue is empty.
- Latency (default build): `imem_rvalid` in cycle N gives `instr_valid`=1 in cycle N+1.
- `pc_en` is never high in the same cycle as `flush`. The PC unit loads the branch target on `PCSrc` itself.
- Empty queue with `instr_ready`=1: no pop, no error.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined:
  - When the queue is empty (count=0), `flush`=0 and state is WAIT with `imem_rvalid`=1, `instr_valid`/`instr`/`instr_pc` present {`req_pc`, `imem_rdata`} combinationally in the same cycle.
  - If `instr_ready`=1 that cycle, the entry is consumed and not written to the queue; otherwise it is written as normal.
  - Zero-cycle fetch-to-decode latency.
- Undefined: no bypass path; latency as in Behaviour.

Test Plan:
- Reset, then `pc_in`=0x00000000, memory responds after 1 cycle with 0x00500093, `instr_ready`=1 -> `imem_req`/`pc_en` pulse in cycle 1; `instr_valid`=1 with `instr`=0x00500093, `instr_pc`=0x0 in cycle 3 (cycle 2 with FETCH_BYPASS_EN).
- Hold `instr_ready`=0, sequential PCs 0x0,0x4,0x8 -> exactly DEPTH=2 entries fill, `imem_req` stays 0 afterwards, head remains PC 0x0. Raising `instr_ready` drains 0x0 then 0x4 in order and a fetch of 0x8 issues.
- Assert `flush` in the cycle after a request to 0x10, memory returns 0xDEADBEEF 3 cycles later -> data dropped, `instr_valid`=0, next request to the new `pc_in` (e.g. 0x40) issues only after the discarded response.
- `flush` and `imem_rvalid` in the same cycle with 1 entry queued -> queue empty next cycle, state IDLE, new request issues in the following cycle.
- Wrap-around: stream 6 instructions with alternating `instr_ready` -> output PCs 0x0,0x4,...,0x14 in order with no loss or duplication.
- Assert `rst` while in WAIT with 1 entry queued -> all outputs 0 immediately; a late `imem_rvalid` is ignored.
